// File: rtl/tt_uart_pkg.sv
// Shared types and pin-map constants for the Tiny Tapeout UART transmitter.
package tt_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int UART_DATA_BITS = 8;

  localparam int UO_TX      = 0;
  localparam int UO_BUSY    = 1;
  localparam int UO_FULL    = 2;
  localparam int UO_EMPTY   = 3;
  localparam int UO_OVF     = 4;
  localparam int UO_CNT_LSB = 5;
  localparam int UO_CNT_W   = 3;

  localparam int UIO_WR      = 0;
  localparam int UIO_OVF_CLR = 1;

  // The count field is only three pins wide, so a full 8-deep FIFO reads as 7.
  function automatic logic [UO_CNT_W-1:0] sat_count3(input int unsigned n);
    return (n > 7) ? 3'd7 : 3'(n);
  endfunction

endpackage

// File: rtl/tt_um_uart_tx_if.sv
// Byte FIFO handshake bundle, plus a bundle of the tt_um pins for host-side use.
interface byte_fifo_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          push;
  logic          pop;
  logic [7:0]    wdata;
  logic [7:0]    rdata;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;

  modport master (output push, pop, wdata, input rdata, full, empty, count);
  modport slave  (input push, pop, wdata, output rdata, full, empty, count);
endinterface

interface tt_um_pins_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] uo_out;

  modport host (output ena, ui_in, uio_in, input uio_out, uio_oe, uo_out);
  modport dut  (input ena, ui_in, uio_in, output uio_out, uio_oe, uo_out);
endinterface

// File: rtl/tt_um_uart_tx_byte_fifo.sv
// Small byte FIFO with registered full/empty/count; read data is the head entry, valid while not empty.
module byte_fifo
  import tt_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  byte_fifo_if.slave  fif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [UART_DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]             r_wr_ptr;
  logic [PW-1:0]             r_rd_ptr;
  logic [CW-1:0]             r_count;
  logic [CW-1:0]             w_count_next;
  logic                      r_full;
  logic                      r_empty;
  logic                      w_do_push;
  logic                      w_do_pop;

  assign w_do_push = fif.push & ~r_full;
  assign w_do_pop  = fif.pop & ~r_empty;

  always_comb begin
    w_count_next = r_count;
    if (w_do_push && !w_do_pop) begin
      w_count_next = r_count + CW'(1);
    end else if (!w_do_push && w_do_pop) begin
      w_count_next = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= fif.wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == CW'(FIFO_DEPTH));
      r_empty <= (w_count_next == '0);
    end
  end

  assign fif.rdata = r_mem[r_rd_ptr];
  assign fif.full  = r_full;
  assign fif.empty = r_empty;
  assign fif.count = r_count;

endmodule

// File: rtl/tt_um_uart_tx.sv
// Tiny Tapeout project: strobed bytes from ui_in are queued and sent as 8N1 UART frames on uo_out[0].
module tt_um_uart_tx
  import tt_uart_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int BW = $clog2(CLK_DIV);

  byte_fifo_if #(.DEPTH(FIFO_DEPTH)) w_fifo ();

  byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .fif   (w_fifo)
  );

  tx_state_t                 r_state;
  logic [BW-1:0]             r_baud;
  logic [2:0]                r_bit;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      r_tx;
  logic                      r_busy;
  logic                      r_wr_prev;
  logic                      r_ovf;

  logic                      w_wr_edge;
  logic                      w_baud_end;
  logic                      w_start;
  logic [UO_CNT_W-1:0]       w_cnt_sat;
  logic                      w_unused;

  assign w_unused   = ^uio_in[7:2];
  assign w_wr_edge  = uio_in[UIO_WR] & ~r_wr_prev & ena;
  assign w_baud_end = (r_baud == BW'(CLK_DIV - 1));

  // A frame may begin from IDLE or straight out of the last STOP cycle, which keeps frames gapless.
  assign w_start = ena & ~w_fifo.empty &
                   ((r_state == IDLE) || ((r_state == STOP) && w_baud_end));

  assign w_fifo.push  = w_wr_edge & ~w_fifo.full;
  assign w_fifo.pop   = w_start;
  assign w_fifo.wdata = ui_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_prev <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_wr_prev <= uio_in[UIO_WR];
      // Full is sampled before any same-edge pop; a set beats a same-edge clear.
      if (w_wr_edge && w_fifo.full) begin
        r_ovf <= 1'b1;
      end else if (uio_in[UIO_OVF_CLR]) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= START;
            r_shift <= w_fifo.rdata;
            r_baud  <= '0;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        START: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= DATA;
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        DATA: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit == 3'(UART_DATA_BITS - 1)) begin
              r_state <= STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1;
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        STOP: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (w_start) begin
              r_state <= START;
              r_shift <= w_fifo.rdata;
              r_tx    <= 1'b0;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign w_cnt_sat = sat_count3(32'(w_fifo.count));

  always_comb begin
    uo_out                           = '0;
    uo_out[UO_TX]                    = r_tx;
    uo_out[UO_BUSY]                  = r_busy;
    uo_out[UO_FULL]                  = w_fifo.full;
    uo_out[UO_EMPTY]                 = w_fifo.empty;
    uo_out[UO_OVF]                   = r_ovf;
    uo_out[UO_CNT_LSB +: UO_CNT_W]   = w_cnt_sat;
  end

  assign uio_out = '0;
  assign uio_oe  = '0;

endmodule

// File: tb/tb_tt_um_uart_tx.sv
// Self-checking bench: a line monitor decodes 8N1 frames from tx; expected bytes/timing come from a queue model.
module tb_tt_um_uart_tx;

  localparam int CLK_DIV = 16;
  localparam int DEPTH   = 4;
  localparam int FRAME   = 10 * CLK_DIV;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  tt_um_pins_if pins ();

  tt_um_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .ui_in   (pins.ui_in),
    .uo_out  (pins.uo_out),
    .uio_in  (pins.uio_in),
    .uio_out (pins.uio_out),
    .uio_oe  (pins.uio_oe),
    .ena     (pins.ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  always #5 clk = ~clk;

  logic       tx, busy, full, empty, ovf;
  logic [2:0] cnt;
  assign tx    = pins.uo_out[0];
  assign busy  = pins.uo_out[1];
  assign full  = pins.uo_out[2];
  assign empty = pins.uo_out[3];
  assign ovf   = pins.uo_out[4];
  assign cnt   = pins.uo_out[7:5];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rst_cnt = 0;
  always @(negedge rst_n) rst_cnt++;

  logic [7:0] rx_data[$];
  int         rx_start[$];
  bit         rx_ok[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Line monitor: sample each bit at its centre; frames cut by a reset are discarded.
  initial begin
    logic       prev;
    int         st;
    int         rc;
    logic [7:0] d;
    bit         okb;
    prev = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rst_n && prev === 1'b1 && tx === 1'b0) begin
        st  = cyc;
        rc  = rst_cnt;
        okb = 1'b1;
        repeat (CLK_DIV / 2) @(posedge clk);
        #1;
        if (tx !== 1'b0) okb = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(posedge clk);
          #1;
          d[i] = tx;
        end
        repeat (CLK_DIV) @(posedge clk);
        #1;
        if (tx !== 1'b1) okb = 1'b0;
        if (rst_cnt == rc) begin
          rx_data.push_back(d);
          rx_start.push_back(st);
          rx_ok.push_back(okb);
          $display("frame: data=0x%02h start_cycle=%0d framing_ok=%0d", d, st, okb);
        end
        prev = tx;
      end else begin
        prev = tx;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got hang required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns the cycle of the edge that sees the strobe rising.
  task automatic push_byte(input logic [7:0] b, output int pc);
    pins.ui_in     = b;
    pins.uio_in[0] = 1'b1;
    tick(1);
    pc = cyc;
    pins.uio_in[0] = 1'b0;
    tick(1);
    $display("push: data=0x%02h edge_cycle=%0d", b, pc);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (busy === 1'b0 && tx === 1'b1) break;
      tick(1);
    end
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rx_data.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    if (rx_data.size() >= n) ok = 1'b1;
  endtask

  task automatic wait_busy_fall(input int budget, output int fall);
    fall = -1;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (busy === 1'b0) begin
        fall = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int pc;
    int bad;
    pins.ena    = 1'b1;
    pins.ui_in  = 8'h00;
    pins.uio_in = 8'h00;
    tick(3);
    n_checks++;
    if (pins.uo_out !== 8'b0000_1001) $display("FAIL reset_uo_out: got %b required %b", pins.uo_out, 8'b0000_1001);
    else n_pass++;
    n_checks++;
    if (pins.uio_out !== 8'h00 || pins.uio_oe !== 8'h00)
      $display("FAIL reset_uio: got out=%h oe=%h required 00/00", pins.uio_out, pins.uio_oe);
    else n_pass++;
    rst_n = 1'b1;
    tick(2);
    // Byte 0x00 keeps tx low mid-frame so the asynchronous release to high is observable.
    push_byte(8'h00, pc);
    tick(40);
    n_checks++;
    if (tx !== 1'b0 || busy !== 1'b1) $display("FAIL midframe_pre: got tx=%b busy=%b required tx=0 busy=1", tx, busy);
    else n_pass++;
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (pins.uo_out !== 8'b0000_1001) $display("FAIL async_reset: got %b required %b", pins.uo_out, 8'b0000_1001);
    else n_pass++;
    tick(2);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (tx !== 1'b1 || busy !== 1'b0 || empty !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL post_reset_idle: got %0d non-idle cycles required 0", bad);
    else n_pass++;
    rx_data.delete();
    rx_start.delete();
    rx_ok.delete();
  endtask

  task automatic test_single();
    logic [7:0] bytes[3];
    int pc, fall, n0;
    bit ok;
    bytes[0] = 8'hA5;
    bytes[1] = 8'($urandom);
    bytes[2] = 8'($urandom);
    for (int k = 0; k < 3; k++) begin
      wait_idle(4 * FRAME);
      n0 = rx_data.size();
      push_byte(bytes[k], pc);
      wait_busy_fall(3 * FRAME, fall);
      wait_frames(n0 + 1, 50, ok);
      n_checks++;
      if (!ok) $display("FAIL single_frame_seen[%0d]: got %0d frames required %0d", k, rx_data.size(), n0 + 1);
      else n_pass++;
      if (ok) begin
        n_checks++;
        if (rx_data[n0] !== bytes[k] || !rx_ok[n0])
          $display("FAIL single_data[%0d]: got 0x%02h ok=%0d required 0x%02h ok=1", k, rx_data[n0], rx_ok[n0], bytes[k]);
        else n_pass++;
        n_checks++;
        if (rx_start[n0] != pc + 1) $display("FAIL single_latency[%0d]: got cycle %0d required %0d", k, rx_start[n0], pc + 1);
        else n_pass++;
        n_checks++;
        if (fall != rx_start[n0] + FRAME) $display("FAIL single_busy_fall[%0d]: got cycle %0d required %0d", k, fall, rx_start[n0] + FRAME);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes[3];
    int pc, fall, n0, peak;
    bit ok;
    bytes[0] = 8'h01;
    bytes[1] = 8'h02;
    bytes[2] = 8'h03;
    wait_idle(4 * FRAME);
    n0 = rx_data.size();
    peak = 0;
    for (int k = 0; k < 3; k++) begin
      push_byte(bytes[k], pc);
      if (int'(cnt) > peak) peak = int'(cnt);
    end
    fall = -1;
    for (int i = 0; i < 4 * FRAME; i++) begin
      tick(1);
      if (int'(cnt) > peak) peak = int'(cnt);
      if (busy === 1'b0) begin
        fall = cyc;
        break;
      end
    end
    wait_frames(n0 + 3, 50, ok);
    n_checks++;
    if (peak != 2) $display("FAIL b2b_peak_count: got %0d required 2", peak);
    else n_pass++;
    n_checks++;
    if (!ok) $display("FAIL b2b_frames_seen: got %0d required %0d", rx_data.size(), n0 + 3);
    else n_pass++;
    if (ok) begin
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (rx_data[n0 + k] !== bytes[k] || !rx_ok[n0 + k])
          $display("FAIL b2b_data[%0d]: got 0x%02h required 0x%02h", k, rx_data[n0 + k], bytes[k]);
        else n_pass++;
      end
      for (int k = 1; k < 3; k++) begin
        n_checks++;
        if (rx_start[n0 + k] - rx_start[n0 + k - 1] != FRAME)
          $display("FAIL b2b_gap[%0d]: got spacing %0d required %0d", k, rx_start[n0 + k] - rx_start[n0 + k - 1], FRAME);
        else n_pass++;
      end
      n_checks++;
      if (fall != rx_start[n0] + 3 * FRAME) $display("FAIL b2b_total: got %0d cycles required %0d", fall - rx_start[n0], 3 * FRAME);
      else n_pass++;
    end
    n_checks++;
    if (empty !== 1'b1) $display("FAIL b2b_empty: got %b required 1", empty);
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int occ, pc, n0;
    bit exp_ovf, ok;
    wait_idle(4 * FRAME);
    n0 = rx_data.size();
    occ = 0;
    exp_ovf = 1'b0;
    // The first byte leaves the queue immediately to start a frame; the rest contend for DEPTH slots.
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom);
      push_byte(b, pc);
      if (k == 0) exp_q.push_back(b);
      else if (occ < DEPTH) begin
        exp_q.push_back(b);
        occ++;
      end else exp_ovf = 1'b1;
    end
    n_checks++;
    if (full !== 1'b1 || int'(cnt) != occ) $display("FAIL ovf_full_count: got full=%b count=%0d required full=1 count=%0d", full, cnt, occ);
    else n_pass++;
    n_checks++;
    if (ovf !== exp_ovf) $display("FAIL ovf_set: got %b required %b", ovf, exp_ovf);
    else n_pass++;
    pins.ui_in  = 8'($urandom);
    pins.uio_in = 8'b0000_0011;
    tick(1);
    pins.uio_in = 8'h00;
    tick(1);
    n_checks++;
    if (ovf !== 1'b1 || int'(cnt) != occ) $display("FAIL ovf_set_beats_clear: got ovf=%b count=%0d required ovf=1 count=%0d", ovf, cnt, occ);
    else n_pass++;
    pins.uio_in[1] = 1'b1;
    tick(1);
    pins.uio_in[1] = 1'b0;
    tick(1);
    n_checks++;
    if (ovf !== 1'b0) $display("FAIL ovf_clear: got %b required 0", ovf);
    else n_pass++;
    wait_frames(n0 + exp_q.size(), (exp_q.size() + 1) * FRAME, ok);
    tick(2 * FRAME);
    n_checks++;
    if (!ok || rx_data.size() != n0 + exp_q.size())
      $display("FAIL ovf_frame_count: got %0d frames required %0d", rx_data.size() - n0, exp_q.size());
    else n_pass++;
    if (ok) begin
      for (int k = 0; k < exp_q.size(); k++) begin
        n_checks++;
        if (rx_data[n0 + k] !== exp_q[k]) $display("FAIL ovf_data[%0d]: got 0x%02h required 0x%02h", k, rx_data[n0 + k], exp_q[k]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_held_strobe();
    int n0, fall;
    wait_idle(4 * FRAME);
    n0 = rx_data.size();
    pins.ui_in     = 8'h3C;
    pins.uio_in[0] = 1'b1;
    tick(50);
    pins.uio_in[0] = 1'b0;
    $display("push: held strobe 50 cycles data=0x3c");
    wait_busy_fall(3 * FRAME, fall);
    tick(FRAME);
    n_checks++;
    if (rx_data.size() != n0 + 1) $display("FAIL held_frame_count: got %0d required 1", rx_data.size() - n0);
    else n_pass++;
    if (rx_data.size() > n0) begin
      n_checks++;
      if (rx_data[n0] !== 8'h3C) $display("FAIL held_data: got 0x%02h required 0x3c", rx_data[n0]);
      else n_pass++;
    end
  endtask

  task automatic test_ena_gating();
    logic [7:0] a, b, c;
    int pc, n0, fall, en_cyc, bad;
    bit ok;
    a = 8'($urandom);
    b = 8'($urandom);
    c = 8'($urandom);
    wait_idle(4 * FRAME);
    n0 = rx_data.size();
    push_byte(a, pc);
    push_byte(b, pc);
    tick(20);
    pins.ena = 1'b0;
    push_byte(c, pc);
    n_checks++;
    if (int'(cnt) != 1 || busy !== 1'b1) $display("FAIL ena_strobe_ignored: got count=%0d busy=%b required count=1 busy=1", cnt, busy);
    else n_pass++;
    wait_busy_fall(2 * FRAME, fall);
    n_checks++;
    if (fall < 0) $display("FAIL ena_frame_completes: got busy still high required busy=0");
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (busy !== 1'b0 || tx !== 1'b1 || int'(cnt) != 1) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL ena_no_start: got %0d cycles with activity required 0", bad);
    else n_pass++;
    pins.ena = 1'b1;
    en_cyc = cyc + 1;
    wait_frames(n0 + 2, 3 * FRAME, ok);
    n_checks++;
    if (!ok) $display("FAIL ena_frames_seen: got %0d required 2", rx_data.size() - n0);
    else n_pass++;
    if (ok) begin
      n_checks++;
      if (rx_data[n0] !== a || rx_data[n0 + 1] !== b)
        $display("FAIL ena_data: got 0x%02h 0x%02h required 0x%02h 0x%02h", rx_data[n0], rx_data[n0 + 1], a, b);
      else n_pass++;
      n_checks++;
      if (rx_start[n0 + 1] != en_cyc) $display("FAIL ena_resume_edge: got cycle %0d required %0d", rx_start[n0 + 1], en_cyc);
      else n_pass++;
    end
    wait_idle(2 * FRAME);
    n_checks++;
    if (empty !== 1'b1) $display("FAIL ena_final_empty: got %b required 1", empty);
    else n_pass++;
  endtask

  task automatic test_random_stream();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int n, pc, n0;
    bit ok;
    for (int r = 0; r < 3; r++) begin
      wait_idle(6 * FRAME);
      n0 = rx_data.size();
      exp_q.delete();
      n = $urandom_range(2, DEPTH + 1);
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        push_byte(b, pc);
        tick($urandom_range(0, 30));
      end
      wait_frames(n0 + n, (n + 1) * FRAME, ok);
      n_checks++;
      if (!ok) $display("FAIL rand_frames[%0d]: got %0d required %0d", r, rx_data.size() - n0, n);
      else n_pass++;
      if (ok) begin
        for (int k = 0; k < n; k++) begin
          n_checks++;
          if (rx_data[n0 + k] !== exp_q[k] || !rx_ok[n0 + k])
            $display("FAIL rand_data[%0d][%0d]: got 0x%02h required 0x%02h", r, k, rx_data[n0 + k], exp_q[k]);
          else n_pass++;
        end
      end
    end
  endtask

  initial begin
    pins.ena    = 1'b1;
    pins.ui_in  = 8'h00;
    pins.uio_in = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_held_strobe();
    test_ena_gating();
    test_random_stream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
